if_fetch_stage: RTL and testbench

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the PC, issues one-outstanding-request reads to instruction memory and honours branch/jump redirects from ID. It presents the fetched word plus PC+4 to IF/ID, or a NOP bubble when no valid instruction is available. A one-entry holding buffer absorbs a response that returns while the pipeline is stalled.

---
 rtl/if_fetch_stage_if.sv | 31 +++
 rtl/if_fetch_stage.sv | 128 ++++++++++++
 tb/tb_if_fetch_stage.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_stage_if
// Brief    : Instruction-memory request/response bus between the fetch stage
//            (master) and instruction memory (slave).
// Revision : 1.0
// ============================================================================
interface if_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_stage
// Brief    : Instruction fetch with single outstanding imem read, branch/jump
//            redirect, stall-absorbing one-entry hold buffer and NOP bubbles.
// Revision : 1.0
// ============================================================================
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  wire              clk,
    input  wire              rst_n,
    input  wire              Stall_Or_Not,
    input  wire              redirect_valid,
    input  wire  [31:0]      redirect_target,
    if_fetch_stage_if.master imem,
    output logic [31:0]      out_Instruction_Data,
    output logic [31:0]      out_Add4_PC_4,
    output logic             out_fetch_valid
);

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inflight_pc;
    logic        r_hb_valid;
    logic [31:0] r_hb_instr;
    logic [31:0] r_hb_pc4;
    logic [31:0] r_out_instr;
    logic [31:0] r_out_pc4;
    logic        r_out_valid;

    logic        w_req_core;
    logic        w_accept;
    logic        w_resp_ok;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_resp_pc4;
    logic [31:0] w_redir_pc;
    logic        w_unused_target_lsbs;

    assign w_req_core = (r_state == ST_REQ) && !r_hb_valid && !redirect_valid;
    assign w_accept   = w_req_core && imem.imem_ready;
    // Only a response to a live request counts; DRAIN responses are dropped.
    assign w_resp_ok  = (r_state == ST_WAIT) && imem.imem_rvalid;
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_resp_pc4 = r_inflight_pc + 32'd4;
    assign w_redir_pc = {redirect_target[31:2], 2'b00};
    assign w_unused_target_lsbs = ^redirect_target[1:0];

    // Request is masked while reset is held so nothing is issued before release.
    assign imem.imem_req  = w_req_core && rst_n;
    assign imem.imem_addr = r_pc;

    assign out_Instruction_Data = r_out_instr;
    assign out_Add4_PC_4        = r_out_pc4;
    assign out_fetch_valid      = r_out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_REQ;
            r_pc          <= RESET_PC;
            r_inflight_pc <= 32'd0;
            r_hb_valid    <= 1'b0;
            r_hb_instr    <= NOP_WORD;
            r_hb_pc4      <= 32'd0;
            r_out_instr   <= NOP_WORD;
            r_out_pc4     <= 32'd0;
            r_out_valid   <= 1'b0;
        end else if (redirect_valid) begin
            // Redirect overrides stall: squash output and buffer, restart pc.
            r_pc        <= w_redir_pc;
            r_hb_valid  <= 1'b0;
            r_out_instr <= NOP_WORD;
            r_out_valid <= 1'b0;
            case (r_state)
                ST_REQ:   r_state <= ST_REQ;
                ST_WAIT:  r_state <= imem.imem_rvalid ? ST_REQ : ST_DRAIN;
                ST_DRAIN: r_state <= imem.imem_rvalid ? ST_REQ : ST_DRAIN;
                default:  r_state <= ST_REQ;
            endcase
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (w_accept) begin
                        r_inflight_pc <= r_pc;
                        r_pc          <= w_pc_plus4;
                        r_state       <= ST_WAIT;
                    end
                end
                ST_WAIT, ST_DRAIN: begin
                    if (imem.imem_rvalid) begin
                        r_state <= ST_REQ;
                    end
                end
                default: r_state <= ST_REQ;
            endcase

            if (!Stall_Or_Not) begin
                if (r_hb_valid) begin
                    r_out_instr <= r_hb_instr;
                    r_out_pc4   <= r_hb_pc4;
                    r_out_valid <= 1'b1;
                    r_hb_valid  <= 1'b0;
                end else if (w_resp_ok) begin
                    r_out_instr <= imem.imem_rdata;
                    r_out_pc4   <= w_resp_pc4;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_instr <= NOP_WORD;
                    r_out_valid <= 1'b0;
                end
            end else if (w_resp_ok) begin
                // Buffer is empty here: a full buffer blocks new requests.
                r_hb_instr <= imem.imem_rdata;
                r_hb_pc4   <= w_resp_pc4;
                r_hb_valid <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_stage
// Brief    : Directed + random bench for if_fetch_stage with an imem model and
//            a transaction-level reference of the fetch behaviour.
// Revision : 1.0
// ============================================================================
module tb_if_fetch_stage;

    localparam logic [31:0] C_RESET_PC = 32'h0040_0000;
    localparam logic [31:0] C_WRAP_PC  = 32'hFFFF_FFFC;
    localparam logic [31:0] C_NOP      = 32'h0000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst_n_b;
    logic        stall, redir, stall_b, redir_b;
    logic [31:0] target, target_b;
    logic [31:0] out_instr, out_pc4, out_instr_b, out_pc4_b;
    logic        out_valid, out_valid_b;

    if_fetch_stage_if bus ();
    if_fetch_stage_if bus_b ();

    if_fetch_stage #(.RESET_PC(C_RESET_PC), .NOP_WORD(C_NOP)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .Stall_Or_Not         (stall),
        .redirect_valid       (redir),
        .redirect_target      (target),
        .imem                 (bus),
        .out_Instruction_Data (out_instr),
        .out_Add4_PC_4        (out_pc4),
        .out_fetch_valid      (out_valid)
    );

    if_fetch_stage #(.RESET_PC(C_WRAP_PC), .NOP_WORD(C_NOP)) dut_b (
        .clk                  (clk),
        .rst_n                (rst_n_b),
        .Stall_Or_Not         (stall_b),
        .redirect_valid       (redir_b),
        .redirect_target      (target_b),
        .imem                 (bus_b),
        .out_Instruction_Data (out_instr_b),
        .out_Add4_PC_4        (out_pc4_b),
        .out_fetch_valid      (out_valid_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Memory environment
    bit          mem_pend;
    int          mem_wait;
    logic [31:0] mem_addr;
    int          lat_mode;
    bit          rdy_random;
    bit          ov_en;
    logic [31:0] ov_data;
    logic [31:0] salt;

    // Reference: busy = a read is outstanding, squash = its data is unwanted
    logic [31:0] m_pc, m_inflight, m_oi, m_op4;
    bit          m_ov, m_busy, m_squash;
    logic [63:0] m_hb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    task automatic drive_mem();
        bus.imem_ready  = mem_pend ? 1'b0 : (rdy_random ? ($urandom_range(0, 3) != 0) : 1'b1);
        bus.imem_rvalid = mem_pend && (mem_wait == 0);
        bus.imem_rdata  = bus.imem_rvalid ? (ov_en ? ov_data : word_of(mem_addr)) : $urandom();
    endtask

    task automatic mem_advance(input bit acc, input logic [31:0] acc_addr);
        if (bus.imem_rvalid) mem_pend = 1'b0;
        if (acc) begin
            mem_pend = 1'b1;
            mem_addr = acc_addr;
            mem_wait = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
        end else if (mem_pend && mem_wait > 0) begin
            mem_wait--;
        end
    endtask

    task automatic model_reset(input logic [31:0] rpc);
        m_pc = rpc; m_inflight = 32'd0;
        m_busy = 1'b0; m_squash = 1'b0;
        m_hb.delete();
        m_oi = C_NOP; m_op4 = 32'd0; m_ov = 1'b0;
    endtask

    function automatic bit exp_req();
        return !m_busy && (m_hb.size() == 0) && !redir;
    endfunction

    task automatic model_step();
        bit          acc     = exp_req() && bus.imem_ready;
        bit          rsp_any = m_busy && bus.imem_rvalid;
        bit          rsp_ok  = rsp_any && !m_squash;
        logic [31:0] rsp_pc4 = m_inflight + 32'd4;
        logic [31:0] rsp_dat = bus.imem_rdata;
        if (redir) begin
            m_pc = {target[31:2], 2'b00};
            m_hb.delete();
            m_oi = C_NOP; m_ov = 1'b0;
            if (rsp_any) begin m_busy = 1'b0; m_squash = 1'b0; end
            else if (m_busy) m_squash = 1'b1;
        end else begin
            if (rsp_any) begin m_busy = 1'b0; m_squash = 1'b0; end
            if (acc) begin
                m_inflight = m_pc; m_pc = m_pc + 32'd4;
                m_busy = 1'b1; m_squash = 1'b0;
            end
            if (!stall) begin
                if (m_hb.size() > 0) begin
                    {m_oi, m_op4} = m_hb.pop_front(); m_ov = 1'b1;
                end else if (rsp_ok) begin
                    m_oi = rsp_dat; m_op4 = rsp_pc4; m_ov = 1'b1;
                end else begin
                    m_oi = C_NOP; m_ov = 1'b0;
                end
            end else if (rsp_ok) begin
                m_hb.push_back({rsp_dat, rsp_pc4});
            end
        end
    endtask

    // One clock: inputs set at negedge by caller, checks before and after posedge.
    task automatic tick();
        bit          acc;
        logic [31:0] a;
        drive_mem();
        #1;
        chk("imem_req", 32'(bus.imem_req), 32'(exp_req()));
        if (exp_req()) chk("imem_addr", bus.imem_addr, m_pc);
        acc = bus.imem_req && bus.imem_ready;
        a   = bus.imem_addr;
        model_step();
        @(posedge clk); #1;
        chk("out_instr", out_instr, m_oi);
        chk("out_pc4", out_pc4, m_op4);
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        mem_advance(acc, a);
        @(negedge clk);
    endtask

    task automatic reset_pulse(input int cycles);
        drive_mem();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_instr", out_instr, C_NOP);
        chk("rst_pc4", out_pc4, 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        model_reset(C_RESET_PC);
        repeat (cycles) begin
            @(posedge clk); #1;
            chk("rst_hold_valid", 32'(out_valid), 32'd0);
            mem_advance(1'b0, 32'd0);
            @(negedge clk);
            drive_mem();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        salt = $urandom();
        rst_n = 1'b0; rst_n_b = 1'b0;
        stall = 1'b0; redir = 1'b0; target = 32'd0;
        stall_b = 1'b0; redir_b = 1'b0; target_b = 32'd0;
        bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'd0;
        bus_b.imem_ready = 1'b0; bus_b.imem_rvalid = 1'b0; bus_b.imem_rdata = 32'd0;
        mem_pend = 1'b0; mem_wait = 0; mem_addr = 32'd0;
        lat_mode = 0; rdy_random = 1'b0; ov_en = 1'b0; ov_data = 32'd0;
        model_reset(C_RESET_PC);

        repeat (3) @(negedge clk);
        chk("reset_instr", out_instr, C_NOP);
        chk("reset_pc4", out_pc4, 32'd0);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_req", 32'(bus.imem_req), 32'd0);
        rst_n = 1'b1;

        // Zero-wait streaming: three instructions with bubbles between
        repeat (6) tick();

        // Response lands during a 3-cycle stall and is held in the buffer
        tick();
        ov_en = 1'b1; ov_data = 32'h2008_0005; stall = 1'b1;
        tick();
        ov_en = 1'b0;
        tick();
        tick();
        stall = 1'b0;
        tick();
        chk("hb_release_instr", out_instr, 32'h2008_0005);
        chk("hb_release_pc4", out_pc4, 32'h0040_0010);

        // Redirect while waiting: squash output, drop the late response
        lat_mode = 1;
        tick();
        redir = 1'b1; target = 32'h0040_0103;
        tick();
        redir = 1'b0;
        chk("redir_wait_valid", 32'(out_valid), 32'd0);
        tick();
        chk("redir_wait_addr", bus.imem_addr, 32'h0040_0100);
        chk("redir_wait_req", 32'(bus.imem_req), 32'd1);

        // Redirect in REQ with memory ready: no accept
        lat_mode = 0;
        redir = 1'b1; target = 32'h0040_0200;
        tick();
        redir = 1'b0;
        chk("redir_req_addr", bus.imem_addr, 32'h0040_0200);

        // Reset while a read is outstanding; its stale rvalid must be ignored
        lat_mode = 2;
        tick();
        reset_pulse(2);
        chk("restart_addr", bus.imem_addr, C_RESET_PC);
        repeat (4) tick();

        // Randomized traffic
        lat_mode = -1; rdy_random = 1'b1;
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            redir  = (r < 6);
            stall  = (r >= 6 && r < 26) || (r == 5);
            target = $urandom();
            if (i == 300) begin
                redir = 1'b0; stall = 1'b0;
                reset_pulse(1);
            end
            tick();
        end
        redir = 1'b0; stall = 1'b0;

        // Address wrap from RESET_PC = 0xFFFF_FFFC
        bus_b.imem_ready = 1'b1;
        rst_n_b = 1'b1;
        #1;
        chk("wrap_req0", 32'(bus_b.imem_req), 32'd1);
        chk("wrap_addr0", bus_b.imem_addr, C_WRAP_PC);
        @(posedge clk);
        @(negedge clk);
        bus_b.imem_rvalid = 1'b1; bus_b.imem_rdata = 32'h1234_5678;
        #1;
        chk("wrap_req_wait", 32'(bus_b.imem_req), 32'd0);
        @(posedge clk); #1;
        chk("wrap_out_pc4", out_pc4_b, 32'h0000_0000);
        chk("wrap_out_instr", out_instr_b, 32'h1234_5678);
        chk("wrap_out_valid", 32'(out_valid_b), 32'd1);
        @(negedge clk);
        bus_b.imem_rvalid = 1'b0;
        #1;
        chk("wrap_req1", 32'(bus_b.imem_req), 32'd1);
        chk("wrap_addr1", bus_b.imem_addr, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
